rv32_mod_data_sram_ctrl: RTL and testbench
==========================================

// Module: rv32_mod_data_sram_ctrl
// PURPOSE
//  Word-addressed data-memory slave answering the load/store unit's external data bus.
//  - Accepts one transaction at a time (req/wr/byte-enable/address/write-data).
//  - Applies configurable wait states, then performs a byte-masked write or a word read
//    on an internal synchronous SRAM.
//  - Returns a one-cycle ack with read data, or a one-cycle err for misaligned or
//    out-of-range accesses.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  DEPTH_WORDS  1024           number of 32-bit words; power of two, >=2
//  WAIT_STATES  0              extra cycles inserted before the SRAM access (0..15)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  data_req     in   1   request valid; held high until data_ack or data_err
//  data_wr      in   1   1 = store, 0 = load; sampled with data_req
//  data_be      in   4   byte enables, bit i = byte lane i (data[8i+7:8i])
//  data_addr    in   32  byte address; bits [1:0] must be 0
//  data_data_i  in   32  store data
//  data_data_o  out  32  load data; valid in the data_ack cycle of a load
//  data_ack     out  1   one-cycle pulse: transaction completed successfully
//  data_err     out  1   one-cycle pulse: transaction rejected, no memory side effect
// BEHAVIOUR
//  - Reset: state=IDLE; data_ack=0, data_err=0, data_data_o=0, wait counter=0.
//    SRAM contents are NOT reset. Reset mid-transaction aborts it with no ack/err;
//    an aborted store may or may not have been written only if ACCESS was reached.
//  - FSM states: IDLE, WAIT, ACCESS, RESP, ERR.
//  - IDLE: when data_req=1, latch wr/be/addr/wdata.
//    - If addr[1:0]!=0, or word index (addr-BASE_ADDR)>>2 >= DEPTH_WORDS (unsigned,
//      so addr<BASE_ADDR wraps and fails), or be==4'b0000 -> ERR.
//    - Else -> WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else ACCESS.
//  - WAIT: counter decrements; at 0 -> ACCESS. Inputs are ignored (latched copy used).
//  - ACCESS: SRAM enable for exactly one cycle.
//    - Store: write lanes with be[i]=1, other lanes untouched.
//    - Load: read the full word (be ignored for loads).
//    - -> RESP.
//  - RESP: data_ack=1 for one cycle; load data on data_data_o. A store leaves
//    data_data_o unchanged. -> IDLE.
//  - ERR: data_err=1 for one cycle, data_data_o unchanged -> IDLE.
//  - Latency: req sampled in cycle N -> ack in N+2+WAIT_STATES, err in N+1.
//  - data_ack and data_err are never high together, and never high outside RESP/ERR.
//  - Requester drops data_req the cycle after ack/err unless it issues a new transaction.
//    data_req high in IDLE always starts a new transaction (back-to-back allowed:
//    one idle cycle between transactions).
//  - data_data_o holds its value between loads (registered output).
//  - Read-after-write to the same word in back-to-back transactions returns the new data.
// STRUCTURE
//  - Package rv32_pkg_data_mem: state enum (IDLE, WAIT, ACCESS, RESP, ERR),
//    word-index width function clog2(DEPTH_WORDS), ERR cause constants for
//    assertions/debug.
//  - Sub-module rv32_mod_bytewise_sram: single-port, 4 byte lanes, en/we/be/addr/wdata,
//    1-cycle registered rdata.
//  - Top holds the FSM, request latch, range check and wait counter.
// TESTING
//  1. Reset, then store 0xDEADBEEF be=1111 at BASE+0x10 and load it back
//     -> ack at N+2 each, load data 0xDEADBEEF.
//  2. Store 0x11223344 be=1111, then 0xAABBCCDD be=0101 same addr, then load
//     -> 0x11BB33DD.
//  3. Load addr BASE+0x2 -> err at N+1, no ack; load BASE+4*DEPTH_WORDS -> err;
//     store be=0000 -> err with memory unchanged.
//  4. WAIT_STATES=3: load -> ack exactly at N+5; data_data_o stable and equal to the
//     previous load until the RESP cycle.
//  5. Assert reset while in WAIT -> no ack/err, state IDLE next cycle, a new load
//     completes normally.
//  6. Back-to-back stream of 100 random aligned loads/stores vs. a scoreboard model
//     -> all data matches, exactly one ack/err per request, never both at once.

Source files
------------

// File: rtl/rv32_pkg_data_mem.sv
// Shared types and constants for the word-addressed data-memory slave.
// State encoding, index-width helper and error-cause codes.
package rv32_pkg_data_mem;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_BE_ZERO  = 2'd3;

    // Smallest width able to index v words (v >= 2).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32_mod_bytewise_sram.sv
// Single-port synchronous SRAM, 32-bit words with four byte-lane write enables.
// Read data is registered and only changes on a read access.
module rv32_mod_bytewise_sram
    import rv32_pkg_data_mem::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Array contents are intentionally left without reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rv32_mod_data_sram_ctrl.sv
// Data-bus slave: validates one request at a time, inserts wait states,
// then performs a byte-masked store or word load on the internal SRAM.
module rv32_mod_data_sram_ctrl
    import rv32_pkg_data_mem::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_i,
    output logic [31:0] data_data_o,
    output logic        data_ack,
    output logic        data_err
);

    localparam int unsigned AW        = clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_wait_cnt;
    logic [3:0]      w_wait_cnt_nxt;
    logic            w_latch;
    logic            r_ack;
    logic            r_err;

    logic            r_wr;
    logic [3:0]      r_be;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;

    logic [29:0]     w_word_off;
    logic [1:0]      w_err_cause;
    logic            w_sram_en;
    logic [31:0]     w_sram_rdata;

    // Unsigned word offset: addresses below BASE_ADDR wrap high and fail the range check.
    assign w_word_off = data_addr[31:2] - BASE_WORD;

    always_comb begin
        w_err_cause = ERR_NONE;
        if (data_addr[1:0] != 2'b00) begin
            w_err_cause = ERR_MISALIGN;
        end else if (w_word_off >= 30'(DEPTH_WORDS)) begin
            w_err_cause = ERR_RANGE;
        end else if (data_be == 4'b0000) begin
            w_err_cause = ERR_BE_ZERO;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_latch        = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_req) begin
                    w_latch = 1'b1;
                    if (w_err_cause != ERR_NONE) begin
                        w_state_nxt = ERR;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt    = WAIT;
                        w_wait_cnt_nxt = 4'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pulses are registered so they line up with the RESP/ERR state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_ack      <= (w_state_nxt == RESP);
            r_err      <= (w_state_nxt == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_wr    <= data_wr;
            r_be    <= data_be;
            r_idx   <= w_word_off[AW-1:0];
            r_wdata <= data_data_i;
        end
    end

    assign w_sram_en = (r_state == ACCESS);

    rv32_mod_bytewise_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_sram (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_sram_en),
        .i_we    (r_wr),
        .i_be    (r_be),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_sram_rdata)
    );

    assign data_data_o = w_sram_rdata;
    assign data_ack    = r_ack;
    assign data_err    = r_err;

endmodule

// File: tb/tb_rv32_mod_data_sram_ctrl.sv
// Directed bench for the data-memory slave: a zero-wait instance and a
// three-wait-state instance sharing the bus stimulus.
module tb_rv32_mod_data_sram_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        req0, req3;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata3;
    logic        ack0, err0, ack3, err3;

    int checks   = 0;
    int failures = 0;
    int n_req0   = 0;
    int n_resp0  = 0;

    rv32_mod_data_sram_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (0)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .data_req    (req0),
        .data_wr     (wr),
        .data_be     (be),
        .data_addr   (addr),
        .data_data_i (wdata),
        .data_data_o (rdata0),
        .data_ack    (ack0),
        .data_err    (err0)
    );

    rv32_mod_data_sram_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (3)
    ) dut3 (
        .clk         (clk),
        .reset       (reset),
        .data_req    (req3),
        .data_wr     (wr),
        .data_be     (be),
        .data_addr   (addr),
        .data_data_i (wdata),
        .data_data_o (rdata3),
        .data_ack    (ack3),
        .data_err    (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ack0) n_resp0++;
        if (err0) n_resp0++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one transaction from an IDLE cycle and waits for its response.
    task automatic run_txn(input int dut, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic got_ack,
                           output logic [31:0] got_data, output logic stable);
        logic [31:0] prev;
        logic        a_s, e_s;
        logic [31:0] d_s;
        prev = (dut == 0) ? rdata0 : rdata3;
        wr = w; be = b; addr = a; wdata = d;
        if (dut == 0) begin req0 = 1'b1; n_req0++; end
        else          req3 = 1'b1;
        lat = -1; got_ack = 1'b0; got_data = '0; stable = 1'b1;
        for (int k = 1; k <= 24 && lat < 0; k++) begin
            @(posedge clk); #1;
            a_s = (dut == 0) ? ack0 : ack3;
            e_s = (dut == 0) ? err0 : err3;
            d_s = (dut == 0) ? rdata0 : rdata3;
            checks++;
            if (a_s && e_s) begin
                failures++;
                $display("FAIL ack_err_overlap dut=%0d ack=%b err=%b required not both", dut, a_s, e_s);
            end
            if (a_s || e_s) begin
                lat = k; got_ack = a_s; got_data = d_s;
            end else if (d_s !== prev) begin
                stable = 1'b0;
            end
        end
        req0 = 1'b0; req3 = 1'b0;
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL response_timeout dut=%0d addr=%h got no ack/err required one", dut, a);
            return;
        end
        @(posedge clk); #1;
        checks++;
        if (((dut == 0) ? (ack0 | err0) : (ack3 | err3)) !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width dut=%0d response still high after one cycle required 0", dut);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req0 = 1'b0; req3 = 1'b0;
        wr = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack0, err0, ack3, err3} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required 0000", {ack0, err0, ack3, err3});
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata3 !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h required 0/0", rdata0, rdata3);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        int lat; logic ack; logic [31:0] d; logic st;
        run_txn(0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF, lat, ack, d, st);
        checks++;
        if (lat !== 2 || ack !== 1'b1) begin
            failures++;
            $display("FAIL store_latency got lat=%0d ack=%b required lat=2 ack=1", lat, ack);
        end
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL store_keeps_data got=%h required 00000000", d);
        end
        run_txn(0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 2 || ack !== 1'b1) begin
            failures++;
            $display("FAIL load_latency got lat=%0d ack=%b required lat=2 ack=1", lat, ack);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_data got=%h required deadbeef", d);
        end
    endtask

    task automatic test_byte_lanes;
        int lat; logic ack; logic [31:0] d; logic st;
        run_txn(0, 1'b1, 4'hF, BASE + 32'h14, 32'h11223344, lat, ack, d, st);
        run_txn(0, 1'b1, 4'b0101, BASE + 32'h14, 32'hAABBCCDD, lat, ack, d, st);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_holds_prev_load got=%h required deadbeef", d);
        end
        run_txn(0, 1'b0, 4'b0000 | 4'b1000, BASE + 32'h14, 32'h0, lat, ack, d, st);
        checks++;
        if (ack !== 1'b1 || d !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL byte_merge got ack=%b data=%h required ack=1 data=11bb33dd", ack, d);
        end
    endtask

    task automatic test_errors;
        int lat; logic ack; logic [31:0] d; logic st;
        run_txn(0, 1'b0, 4'hF, BASE + 32'h2, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL err_misaligned got lat=%0d ack=%b required lat=1 ack=0", lat, ack);
        end
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL err_keeps_data got=%h required 11bb33dd", d);
        end
        run_txn(0, 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL err_range_high got lat=%0d ack=%b required lat=1 ack=0", lat, ack);
        end
        run_txn(0, 1'b0, 4'hF, BASE - 32'h4, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL err_below_base got lat=%0d ack=%b required lat=1 ack=0", lat, ack);
        end
        run_txn(0, 1'b0, 4'hF, BASE + 32'(4 * (DEPTH - 1)), 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 2 || ack !== 1'b1) begin
            failures++;
            $display("FAIL last_word_ok got lat=%0d ack=%b required lat=2 ack=1", lat, ack);
        end
        run_txn(0, 1'b1, 4'h0, BASE + 32'h14, 32'hFFFFFFFF, lat, ack, d, st);
        checks++;
        if (lat !== 1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL err_be_zero got lat=%0d ack=%b required lat=1 ack=0", lat, ack);
        end
        run_txn(0, 1'b0, 4'hF, BASE + 32'h14, 32'h0, lat, ack, d, st);
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL be_zero_no_write got=%h required 11bb33dd", d);
        end
    endtask

    task automatic test_wait_states;
        int lat; logic ack; logic [31:0] d; logic st;
        run_txn(3, 1'b1, 4'hF, BASE + 32'h8, 32'hCAFEF00D, lat, ack, d, st);
        checks++;
        if (lat !== 5 || ack !== 1'b1) begin
            failures++;
            $display("FAIL ws_store_latency got lat=%0d ack=%b required lat=5 ack=1", lat, ack);
        end
        run_txn(3, 1'b1, 4'hF, BASE + 32'hC, 32'h0BADC0DE, lat, ack, d, st);
        run_txn(3, 1'b0, 4'hF, BASE + 32'h8, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 5 || ack !== 1'b1 || d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL ws_load got lat=%0d ack=%b data=%h required lat=5 ack=1 data=cafef00d", lat, ack, d);
        end
        checks++;
        if (st !== 1'b1) begin
            failures++;
            $display("FAIL ws_data_stable_first got stable=%b required 1", st);
        end
        run_txn(3, 1'b0, 4'hF, BASE + 32'hC, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 5 || d !== 32'h0BADC0DE || st !== 1'b1) begin
            failures++;
            $display("FAIL ws_load_second got lat=%0d data=%h stable=%b required 5/0badc0de/1", lat, d, st);
        end
    endtask

    task automatic test_reset_in_wait;
        int lat; logic ack; logic [31:0] d; logic st;
        logic seen;
        wr = 1'b0; be = 4'hF; addr = BASE + 32'h8; req3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; req3 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ack3, err3} !== 2'b00 || rdata3 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_wait got flags=%b data=%h required 00/00000000", {ack3, err3}, rdata3);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack3 || err3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL aborted_no_response got a response pulse required none");
        end
        run_txn(3, 1'b0, 4'hF, BASE + 32'hC, 32'h0, lat, ack, d, st);
        checks++;
        if (lat !== 5 || ack !== 1'b1 || d !== 32'h0BADC0DE) begin
            failures++;
            $display("FAIL load_after_abort got lat=%0d ack=%b data=%h required 5/1/0badc0de", lat, ack, d);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic ack; logic [31:0] d; logic st;
        logic [31:0] model [8];
        logic        w;
        logic [3:0]  b;
        logic [31:0] v;
        int          idx;
        int          bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            model[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
            run_txn(0, 1'b1, 4'hF, BASE + 32'(4 * i), model[i], lat, ack, d, st);
        end
        for (int n = 0; n < 100; n++) begin
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom_range(0, 15));
            v   = $urandom;
            idx = int'($urandom_range(0, 7));
            run_txn(0, w, b, BASE + 32'(4 * idx), v, lat, ack, d, st);
            if (b == 4'h0) begin
                if (lat != 1 || ack !== 1'b0) bad++;
            end else begin
                if (lat != 2 || ack !== 1'b1) bad++;
                if (w) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) model[idx][8*i +: 8] = v[8*i +: 8];
                    end
                end else if (d !== model[idx]) begin
                    bad++;
                    $display("FAIL stream_load word=%0d got=%h required %h", idx, d, model[idx]);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stream_errors got=%0d required 0", bad);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_resp0 !== n_req0) begin
            failures++;
            $display("FAIL response_count got=%0d required %0d", n_resp0, n_req0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_wait_states();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
